// File: rtl/spi_rx_slave.sv
// SPI responder: synchronizes SS_n/SCLK/MOSI into clk, shifts in an 8/16-bit
// packet and drives the tx_data response on MISO, MSB first.
module spi_rx_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  input  logic        pos_edge,
  input  logic        width8,
  input  logic [15:0] tx_data,
  input  logic        clr_rdy,
  output logic [15:0] rx_data,
  output logic        rdy,
  output logic        MISO
);

  typedef enum logic [1:0] {IDLE, RX, DONE} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] ss_pipe, sclk_pipe, mosi_pipe;
  logic ss_hist, sclk_hist;
  logic ss_s, sclk_s, mosi_s;
  logic ss_fall, ss_rise, sclk_rise, sclk_fall;
  logic smp_edge, shf_edge, pkt_done;
  logic [4:0]  bit_cnt, bit_target;
  logic [15:0] rx_shft, tx_shft;

  // Input synchronizers; SS_n resets to "selected" so a frame already in
  // progress at reset release does not look like a fresh SS_n fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_pipe   <= '0;
      sclk_pipe <= '0;
      mosi_pipe <= '0;
      ss_hist   <= 1'b0;
      sclk_hist <= 1'b0;
    end else begin
      ss_pipe   <= {ss_pipe[SYNC_STAGES-2:0], SS_n};
      sclk_pipe <= {sclk_pipe[SYNC_STAGES-2:0], SCLK};
      mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], MOSI};
      ss_hist   <= ss_pipe[SYNC_STAGES-1];
      sclk_hist <= sclk_pipe[SYNC_STAGES-1];
    end
  end

  assign ss_s   = ss_pipe[SYNC_STAGES-1];
  assign sclk_s = sclk_pipe[SYNC_STAGES-1];
  assign mosi_s = mosi_pipe[SYNC_STAGES-1];

  assign ss_fall   = ss_hist & ~ss_s;
  assign ss_rise   = ~ss_hist & ss_s;
  assign sclk_rise = ~sclk_hist & sclk_s & ~ss_s;
  assign sclk_fall = sclk_hist & ~sclk_s & ~ss_s;

  assign smp_edge   = pos_edge ? sclk_fall : sclk_rise;
  assign shf_edge   = pos_edge ? sclk_rise : sclk_fall;
  assign bit_target = width8 ? 5'd8 : 5'd16;
  assign pkt_done   = (state == RX) && (bit_cnt == bit_target);

  // Frame control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ss_fall) state_nxt = RX;
      RX:      if (pkt_done) state_nxt = DONE;
               else if (ss_rise) state_nxt = IDLE;
      DONE:    if (ss_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Shift registers and bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_shft <= '0;
      tx_shft <= '0;
      bit_cnt <= '0;
    end else if (state == IDLE && ss_fall) begin
      tx_shft <= width8 ? {tx_data[7:0], 8'h00} : tx_data;
      rx_shft <= '0;
      bit_cnt <= '0;
    end else if (state == RX && !pkt_done) begin
      if (smp_edge) begin
        rx_shft <= {rx_shft[14:0], mosi_s};
        bit_cnt <= bit_cnt + 5'd1;
      end
      if (shf_edge && bit_cnt != 5'd0)
        tx_shft <= {tx_shft[14:0], 1'b0};
    end
  end

  // Parallel output; a completing packet beats a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data <= '0;
      rdy     <= 1'b0;
    end else if (pkt_done) begin
      rx_data <= width8 ? {8'h00, rx_shft[7:0]} : rx_shft;
      rdy     <= 1'b1;
    end else if (clr_rdy) begin
      rdy     <= 1'b0;
    end
  end

  assign MISO = ~ss_s & tx_shft[15];

endmodule
